// File: rtl/fb_pkg.sv
// Shared timing constants, default geometry and state type for the framebuffer scan arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fb_pkg;

  // 640x480p60 timing generator positions
  localparam int HA_END = 639;
  localparam int LINE   = 799;
  localparam int VA_END = 479;
  localparam int SCREEN = 524;

  // Default framebuffer geometry
  localparam int FB_W_DEF   = 160;
  localparam int FB_H_DEF   = 120;
  localparam int PIX_W_DEF  = 4;
  localparam int ADDR_W_DEF = 15;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fb_arb_state_t;

  // Display line that the next horizontal blanking burst prepares
  function automatic logic [9:0] target_line(input logic [9:0] sy);
    return (sy == 10'(SCREEN)) ? 10'd0 : sy + 10'd1;
  endfunction

endpackage

// File: rtl/fb_scan_arbiter_if.sv
// RAM, line-buffer and draw-client signals of the scan arbiter, bundled.
// Latency: n/a (wiring only).
// Backpressure: draw side holds drw_req/attributes until drw_gnt.
interface fb_scan_arbiter_if
  import fb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PIX_W  = PIX_W_DEF
);
  // framebuffer RAM
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [PIX_W-1:0]  mem_wdata;
  logic [PIX_W-1:0]  mem_rdata;
  // display line buffer
  logic              lb_we;
  logic [7:0]        lb_addr;
  logic [PIX_W-1:0]  lb_wdata;
  // drawing client
  logic              drw_req;
  logic              drw_we;
  logic [ADDR_W-1:0] drw_addr;
  logic [PIX_W-1:0]  drw_wdata;
  logic              drw_gnt;
  logic              drw_rvalid;
  logic [PIX_W-1:0]  drw_rdata;

  // arbiter side
  modport master (
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata,
    output lb_we, lb_addr, lb_wdata,
    input  drw_req, drw_we, drw_addr, drw_wdata,
    output drw_gnt, drw_rvalid, drw_rdata
  );

  // RAM / line buffer / draw engine side
  modport slave (
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata,
    input  lb_we, lb_addr, lb_wdata,
    output drw_req, drw_we, drw_addr, drw_wdata,
    input  drw_gnt, drw_rvalid, drw_rdata
  );

endinterface

// File: rtl/fb_fetch_seq.sv
// Burst address sequencer: word counter, row base accumulator, line-buffer write pipe.
// Latency: line-buffer write lags the RAM read address by 1 cycle.
// Backpressure: none; a burst runs to completion unless aborted or reset.
module fb_fetch_seq
  import fb_pkg::*;
#(
  parameter int FB_W   = FB_W_DEF,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_pix,
  input  logic              rst_n,
  input  logic              start,      // first word of a burst issued this cycle
  input  logic              line0,      // burst targets framebuffer line 0
  input  logic              issue,      // a burst word is read this cycle
  input  logic              abort,      // drop the rest of the burst
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              last,
  output logic              lb_we,
  output logic [7:0]        lb_addr,
  output logic [PIX_W-1:0]  lb_wdata
);

  // A burst never runs past the end of horizontal blanking
  localparam int BURST_W = (FB_W < LINE - HA_END) ? FB_W : LINE - HA_END;
  localparam int CNT_W   = (BURST_W > 1) ? $clog2(BURST_W) : 1;

  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] base_eff;

  // Line 0 restarts from address 0 in the very cycle its burst starts
  assign base_eff = (start && line0) ? '0 : row_base;
  assign rd_addr  = base_eff + ADDR_W'(cnt);
  assign last     = (cnt == CNT_W'(BURST_W - 1));
  // RAM data lands one cycle after its address, aligned with the registered strobe
  assign lb_wdata = mem_rdata;

  // Word counter, row base and delayed line-buffer strobe/index
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      row_base <= '0;
      lb_we    <= 1'b0;
      lb_addr  <= '0;
    end else begin
      lb_we   <= issue;
      lb_addr <= 8'(cnt);
      if (abort) begin
        cnt <= '0;
      end else if (issue) begin
        if (last) begin
          cnt      <= '0;
          row_base <= base_eff + ADDR_W'(FB_W);
        end else begin
          cnt <= cnt + CNT_W'(1);
          if (start && line0) begin
            row_base <= '0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/fb_scan_arbiter.sv
// Shares one single-port framebuffer RAM between line-buffer scanout bursts and a draw client.
// Latency: burst word k read at sx=640+k, written to line buffer next cycle; draw grant same cycle, read data +1.
// Backpressure: scanout always wins; drw_req is held off (drw_gnt=0) for the whole burst.
// Optional: define ARB_STATS_EN to add the drw_stall_cnt output.
module fb_scan_arbiter
  import fb_pkg::*;
#(
  parameter int FB_W   = FB_W_DEF,
  parameter int FB_H   = FB_H_DEF,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                     clk_pix,
  input  logic                     rst_n,
  input  logic [9:0]               sx,
  input  logic [9:0]               sy,
  fb_scan_arbiter_if.master        bus,
  output logic                     fetch_busy
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]              drw_stall_cnt
`endif
);

  // Lines beyond the visible area are never fetched
  localparam int FETCH_LINES = (FB_H < VA_END + 1) ? FB_H : VA_END + 1;

  fb_arb_state_t     state;
  logic [9:0]        burst_sy;
  logic [9:0]        t_line;
  logic              trigger;
  logic              start;
  logic              abort;
  logic              issue;
  logic              last;
  logic [ADDR_W-1:0] rd_addr;

  assign t_line  = target_line(sy);
  assign trigger = (sx == 10'(HA_END + 1)) && (t_line < 10'(FETCH_LINES));
  assign start   = trigger && (state == IDLE);
  // sy moving while a burst is in flight means the timing source jumped
  assign abort   = (state == FETCH) && (sy != burst_sy);
  assign issue   = start || ((state == FETCH) && !abort);

  assign bus.drw_gnt   = bus.drw_req && (state == IDLE) && !trigger;
  assign bus.drw_rdata = bus.mem_rdata;
  assign fetch_busy    = start || (state == FETCH) || bus.lb_we;

  fb_fetch_seq #(
    .FB_W  (FB_W),
    .PIX_W (PIX_W),
    .ADDR_W(ADDR_W)
  ) u_fetch_seq (
    .clk_pix  (clk_pix),
    .rst_n    (rst_n),
    .start    (start),
    .line0    (t_line == 10'd0),
    .issue    (issue),
    .abort    (abort),
    .mem_rdata(bus.mem_rdata),
    .rd_addr  (rd_addr),
    .last     (last),
    .lb_we    (bus.lb_we),
    .lb_addr  (bus.lb_addr),
    .lb_wdata (bus.lb_wdata)
  );

  // Arbitration state: enter FETCH on the blanking trigger, leave after the last word or on a jump
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      burst_sy <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            burst_sy <= sy;
            if (!last) begin
              state <= FETCH;
            end
          end
        end
        FETCH: begin
          if (abort || last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM port mux: burst reads by default, draw client only when granted
  always_comb begin
    bus.mem_addr  = rd_addr;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    if (bus.drw_gnt) begin
      bus.mem_addr  = bus.drw_addr;
      bus.mem_we    = bus.drw_we;
      bus.mem_wdata = bus.drw_wdata;
    end
  end

  // Draw read data returns one cycle after a granted read
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      bus.drw_rvalid <= 1'b0;
    end else begin
      bus.drw_rvalid <= bus.drw_gnt && !bus.drw_we;
    end
  end

`ifdef ARB_STATS_EN
  // Cycles a draw request waits behind scanout; saturating, cleared at frame start
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      drw_stall_cnt <= '0;
    end else if (sx == 10'd0 && sy == 10'd0) begin
      drw_stall_cnt <= '0;
    end else if (bus.drw_req && !bus.drw_gnt && (drw_stall_cnt != 16'hFFFF)) begin
      drw_stall_cnt <= drw_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Scoreboard bench for fb_scan_arbiter: RAM model, expected line-buffer writes and draw reads queued.
// Latency: n/a.
// Backpressure: n/a.
module tb_fb_scan_arbiter;
  import fb_pkg::*;

  localparam int FB_W   = 160;
  localparam int FB_H   = 120;
  localparam int PIX_W  = 4;
  localparam int ADDR_W = 15;

  typedef struct {
    logic [7:0]       idx;
    logic [PIX_W-1:0] dat;
  } lb_exp_t;

  logic       clk_pix = 1'b0;
  logic       rst_n   = 1'b0;
  logic [9:0] sx      = '0;
  logic [9:0] sy      = '0;
  logic       fetch_busy;
`ifdef ARB_STATS_EN
  logic [15:0] drw_stall_cnt;
`endif

  fb_scan_arbiter_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) bus ();

  fb_scan_arbiter #(
    .FB_W  (FB_W),
    .FB_H  (FB_H),
    .PIX_W (PIX_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk_pix   (clk_pix),
    .rst_n     (rst_n),
    .sx        (sx),
    .sy        (sy),
    .bus       (bus),
    .fetch_busy(fetch_busy)
`ifdef ARB_STATS_EN
    ,
    .drw_stall_cnt(drw_stall_cnt)
`endif
  );

  always #5 clk_pix = ~clk_pix;

  int total = 0;
  int bad   = 0;
  int lb_cnt = 0;

  lb_exp_t          lb_q[$];
  logic [PIX_W-1:0] rd_q[$];

  // burst tracking derived from the timing inputs the bench drives
  logic [ADDR_W-1:0] exp_base = '0;
  logic [ADDR_W-1:0] fk_base  = '0;
  int                fk       = 0;
  logic              fk_on    = 1'b0;

  // values sampled at the falling edge of the last tick
  logic              s_gnt;
  logic              s_mem_we;
  logic [ADDR_W-1:0] s_mem_addr;
  logic [PIX_W-1:0]  s_mem_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // RAM contents: a fixed address pattern, overlaid by writes (stored as xor delta)
  function automatic logic [PIX_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8] ^ {1'b0, a[14:12]};
  endfunction

  bit   [PIX_W-1:0] ram_d [0:(1<<ADDR_W)-1];
  logic [PIX_W-1:0] rdata_q = '0;

  function automatic logic [PIX_W-1:0] ram_val(input logic [ADDR_W-1:0] a);
    return ram_d[a] ^ pat(a);
  endfunction

  always @(posedge clk_pix) begin
    if (bus.mem_we === 1'b1) ram_d[bus.mem_addr] <= bus.mem_wdata ^ pat(bus.mem_addr);
    rdata_q <= ram_val(bus.mem_addr);
  end
  assign bus.mem_rdata = rdata_q;

  // Output side of the scoreboard
  always @(negedge clk_pix) begin
    lb_exp_t e;
    if (bus.lb_we === 1'b1) begin
      lb_cnt++;
      if (lb_q.size() == 0) chk("lb_extra", 1, 0);
      else begin
        e = lb_q.pop_front();
        chk("lb_addr", bus.lb_addr, e.idx);
        chk("lb_data", bus.lb_wdata, e.dat);
      end
    end
    if (bus.drw_rvalid === 1'b1) begin
      if (rd_q.size() == 0) chk("rv_extra", 1, 0);
      else chk("rd_data", bus.drw_rdata, rd_q.pop_front());
    end
  end

  // One pixel clock with the current sx/sy; queues a burst when this is a trigger cycle
  task automatic tick();
    logic [9:0] t;
    t = (sy == 10'd524) ? 10'd0 : sy + 10'd1;
    if (sx == 10'd640 && t < FB_H) begin
      if (t == 10'd0) exp_base = '0;
      fk_base = exp_base;
      fk      = 0;
      fk_on   = 1'b1;
      for (int k = 0; k < FB_W; k++) begin
        lb_q.push_back('{idx: 8'(k), dat: ram_val(fk_base + ADDR_W'(k))});
      end
      exp_base = exp_base + ADDR_W'(FB_W);
    end
    @(negedge clk_pix);
    s_gnt       = bus.drw_gnt;
    s_mem_we    = bus.mem_we;
    s_mem_addr  = bus.mem_addr;
    s_mem_wdata = bus.mem_wdata;
    if (sx == 10'd640 && t >= FB_H) chk("no_trig", fetch_busy, 0);
    if (fk_on) begin
      chk("rd_addr", bus.mem_addr, fk_base + ADDR_W'(fk));
      chk("rd_we", bus.mem_we, 0);
      chk("busy", fetch_busy, 1);
      if (bus.drw_req) chk("gnt_held", bus.drw_gnt, 0);
      fk++;
      if (fk == FB_W) fk_on = 1'b0;
    end
    @(posedge clk_pix);
    #1;
  endtask

  task automatic adv();
    if (sx == 10'd799) begin
      sx = '0;
      sy = (sy == 10'd524) ? 10'd0 : sy + 10'd1;
    end else begin
      sx = sx + 10'd1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      adv();
    end
  endtask

  initial begin
    int n;
    int c0;
    logic got;
    bus.drw_req   = 1'b0;
    bus.drw_we    = 1'b0;
    bus.drw_addr  = '0;
    bus.drw_wdata = '0;

    // reset state
    repeat (3) @(negedge clk_pix);
    chk("rst_busy", fetch_busy, 0);
    chk("rst_lb_we", bus.lb_we, 0);
    chk("rst_rvalid", bus.drw_rvalid, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    @(posedge clk_pix);
    #1 rst_n = 1'b1;

    // line-0 prefetch from sy=524, then line 1 from sy=0
    sx = 10'd630; sy = 10'd524; run(180);
    chk("lb_left_l0", lb_q.size(), 0);
    sx = 10'd630; sy = 10'd0; run(180);
    chk("lb_left_l1", lb_q.size(), 0);

    // target line 120 is outside the framebuffer
    sx = 10'd630; sy = 10'd119; c0 = lb_cnt; run(180);
    chk("no_fetch_t120", lb_cnt - c0, 0);

    // draw write arriving with the trigger waits out the burst
    sx = 10'd630; sy = 10'd1; run(10);
    bus.drw_req = 1'b1; bus.drw_we = 1'b1; bus.drw_addr = 15'd77; bus.drw_wdata = 4'h5;
    n = 0; got = 1'b0;
    while (!got && n < 300) begin
      tick();
      if (s_gnt) got = 1'b1;
      else n++;
      adv();
    end
    bus.drw_req = 1'b0;
    chk("gnt_wait", n, 160);
    chk("wr_we", s_mem_we, 1);
    chk("wr_addr", s_mem_addr, 77);
    chk("wr_data", s_mem_wdata, 5);
`ifdef ARB_STATS_EN
    chk("stall_160", drw_stall_cnt, 160);
`endif

    // draw accesses while idle
    bus.drw_req = 1'b1; bus.drw_we = 1'b0; bus.drw_addr = 15'd300;
    rd_q.push_back(ram_val(15'd300));
    tick(); adv();
    chk("rd300_gnt", s_gnt, 1);
    bus.drw_addr = 15'd77;
    rd_q.push_back(4'h5);
    tick(); adv();
    chk("rd77_gnt", s_gnt, 1);
    bus.drw_we = 1'b1; bus.drw_addr = 15'd500; bus.drw_wdata = 4'hA;
    tick(); adv();
    chk("wr500_gnt", s_gnt, 1);
    chk("wr500_we", s_mem_we, 1);
    bus.drw_we = 1'b0;
    rd_q.push_back(4'hA);
    tick(); adv();
    bus.drw_req = 1'b0;
    run(2);
    chk("rd_left", rd_q.size(), 0);
    chk("lb_left_l2", lb_q.size(), 0);

    // reset at word 50 of a burst
    sx = 10'd630; sy = 10'd3; run(60);
    rst_n = 1'b0;
    lb_q.delete();
    fk_on = 1'b0;
    exp_base = '0;
    @(negedge clk_pix);
    chk("mid_rst_lb_we", bus.lb_we, 0);
    chk("mid_rst_busy", fetch_busy, 0);
    chk("mid_rst_mem_we", bus.mem_we, 0);
    chk("mid_rst_rvalid", bus.drw_rvalid, 0);
    @(posedge clk_pix); #1;
    @(posedge clk_pix); #1 rst_n = 1'b1;
    c0 = lb_cnt;
    run(750);
    chk("no_lb_after_rst", lb_cnt - c0, 0);
    run(180);
    chk("lb_left_rst", lb_q.size(), 0);

`ifdef ARB_STATS_EN
    // back-to-back bursts keep a draw request stalled past saturation
    sy = 10'd10;
    bus.drw_req = 1'b1; bus.drw_we = 1'b1; bus.drw_addr = 15'd77; bus.drw_wdata = 4'h5;
    repeat (440) begin
      sx = 10'd640;
      repeat (FB_W) begin
        tick();
        sx = sx + 10'd1;
      end
    end
    bus.drw_req = 1'b0;
    chk("stall_sat", drw_stall_cnt, 16'hFFFF);
    sx = 10'd0; sy = 10'd0;
    tick(); adv();
    chk("stall_clr", drw_stall_cnt, 0);
    chk("lb_left_sat", lb_q.size(), 0);
`endif

    chk("lb_left_end", lb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
